msft_dv_ip_i2c_xfer_sched: RTL and testbench

// - Sequences one I2C transfer per command between the TX/RX byte FIFOs and the I2C byte engine.
// - Issues START, then the address byte, then N data bytes, then STOP.
// - Pops the TX FIFO on writes and pushes the RX FIFO on reads; stalls when the TX FIFO is empty or the RX FIFO is full.
// - Sits between the I2C register block (command source) and the engine/FIFO datapath.

---
 rtl/msft_dv_ip_i2c_xfer_sched.sv | 217 +++++++++++++++++++++
 tb/tb_msft_dv_ip_i2c_xfer_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msft_dv_ip_i2c_xfer_sched.sv
// I2C transfer scheduler: START, address, N data bytes, STOP per command.
// Optional stall watchdog is built when I2C_SCHED_TIMEOUT_EN is defined.
module msft_dv_ip_i2c_xfer_sched #(
    parameter int LEN_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [6:0]          cmd_addr_i,
    input  logic                cmd_rnw_i,
    input  logic [LEN_BITS-1:0] cmd_len_i,
    input  logic                tx_empty_i,
    input  logic [7:0]          tx_rdata_i,
    output logic                tx_rd_o,
    input  logic                rx_full_i,
    output logic                rx_wr_o,
    output logic [7:0]          rx_wdata_o,
    output logic                eng_req_o,
    output logic [1:0]          eng_op_o,
    output logic [7:0]          eng_wdata_o,
    output logic                eng_nack_o,
    input  logic                eng_done_i,
    input  logic                eng_nack_i,
    input  logic [7:0]          eng_rdata_i,
    output logic                busy_o,
    output logic                stall_o,
    output logic [LEN_BITS-1:0] byte_cnt_o,
    output logic                done_o,
    output logic                err_nack_o,
    output logic                err_tmo_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA_WAIT,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    state_t              state_q;
    logic [6:0]          addr_q;
    logic                rnw_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt_q;
    logic [LEN_BITS-1:0] cnt_inc;
    logic                nack_flag_q;
    logic                accept;
    logic                wait_block;
    logic                tmo_hit;

    assign accept      = cmd_valid_i & (state_q == S_IDLE);
    assign wait_block  = rnw_q ? rx_full_i : tx_empty_i;
    assign cnt_inc     = cnt_q + 1'b1;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign stall_o     = (state_q == S_DATA_WAIT) & wait_block;
    assign byte_cnt_o  = cnt_q;

`ifdef I2C_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_flag_q;
    logic          stop_done;

    assign tmo_hit   = stall_o && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign stop_done = (state_q == S_STOP) & eng_req_o & eng_done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
            err_tmo_o  <= 1'b0;
        end else begin
            err_tmo_o <= 1'b0;
            if (!stall_o || tmo_hit) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_hit) begin
                tmo_flag_q <= 1'b1;
            end else if (stop_done) begin
                err_tmo_o  <= tmo_flag_q;
                tmo_flag_q <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign err_tmo_o = 1'b0;
`endif

    // eng_req_o always drops for a cycle between operations
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            nack_flag_q <= 1'b0;
            eng_req_o   <= 1'b0;
            eng_op_o    <= OP_START;
            eng_wdata_o <= '0;
            eng_nack_o  <= 1'b0;
            tx_rd_o     <= 1'b0;
            rx_wr_o     <= 1'b0;
            rx_wdata_o  <= '0;
            done_o      <= 1'b0;
            err_nack_o  <= 1'b0;
        end else begin
            tx_rd_o    <= 1'b0;
            rx_wr_o    <= 1'b0;
            done_o     <= 1'b0;
            err_nack_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q      <= cmd_addr_i;
                        rnw_q       <= cmd_rnw_i;
                        len_q       <= cmd_len_i;
                        cnt_q       <= '0;
                        nack_flag_q <= 1'b0;
                        eng_req_o   <= 1'b1;
                        eng_op_o    <= OP_START;
                        eng_nack_o  <= 1'b0;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    if (eng_done_i) begin
                        eng_req_o <= 1'b0;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!eng_req_o) begin
                        eng_req_o   <= 1'b1;
                        eng_op_o    <= OP_WRITE;
                        eng_wdata_o <= {addr_q, rnw_q};
                        eng_nack_o  <= 1'b0;
                    end else if (eng_done_i) begin
                        eng_req_o <= 1'b0;
                        if (eng_nack_i) begin
                            nack_flag_q <= 1'b1;
                            state_q     <= S_STOP;
                        end else if (len_q == '0) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q <= S_DATA_WAIT;
                        end
                    end
                end
                S_DATA_WAIT: begin
                    if (tmo_hit) begin
                        state_q <= S_STOP;
                    end else if (!wait_block) begin
                        eng_req_o <= 1'b1;
                        state_q   <= S_DATA;
                        if (rnw_q) begin
                            eng_op_o   <= OP_READ;
                            eng_nack_o <= (cnt_q == len_q - 1'b1);
                        end else begin
                            eng_op_o    <= OP_WRITE;
                            eng_wdata_o <= tx_rdata_i;
                            eng_nack_o  <= 1'b0;
                            tx_rd_o     <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (eng_done_i) begin
                        eng_req_o <= 1'b0;
                        cnt_q     <= cnt_inc;
                        if (rnw_q) begin
                            rx_wr_o    <= 1'b1;
                            rx_wdata_o <= eng_rdata_i;
                        end
                        if (!rnw_q && eng_nack_i) begin
                            nack_flag_q <= 1'b1;
                            state_q     <= S_STOP;
                        end else if (cnt_inc == len_q) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q <= S_DATA_WAIT;
                        end
                    end
                end
                S_STOP: begin
                    if (!eng_req_o) begin
                        eng_req_o  <= 1'b1;
                        eng_op_o   <= OP_STOP;
                        eng_nack_o <= 1'b0;
                    end else if (eng_done_i) begin
                        eng_req_o   <= 1'b0;
                        state_q     <= S_IDLE;
                        done_o      <= 1'b1;
                        err_nack_o  <= nack_flag_q;
                        nack_flag_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msft_dv_ip_i2c_xfer_sched.sv
// Scoreboard bench for the I2C transfer scheduler: engine, TX FIFO and
// RX FIFO models run inside a per-cycle tick task driven from one process.
module tb_msft_dv_ip_i2c_xfer_sched;

    localparam int LB = 8;
    localparam logic [1:0] OP_ST = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_RD = 2'd2;
    localparam logic [1:0] OP_SP = 2'd3;
    localparam logic [35:0] RST_OUTS = {1'b1, 35'd0};

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [6:0]    cmd_addr_i;
    logic          cmd_rnw_i;
    logic [LB-1:0] cmd_len_i;
    logic          tx_empty_i;
    logic [7:0]    tx_rdata_i;
    logic          tx_rd_o;
    logic          rx_full_i;
    logic          rx_wr_o;
    logic [7:0]    rx_wdata_o;
    logic          eng_req_o;
    logic [1:0]    eng_op_o;
    logic [7:0]    eng_wdata_o;
    logic          eng_nack_o;
    logic          eng_done_i;
    logic          eng_nack_i;
    logic [7:0]    eng_rdata_i;
    logic          busy_o;
    logic          stall_o;
    logic [LB-1:0] byte_cnt_o;
    logic          done_o;
    logic          err_nack_o;
    logic          err_tmo_o;

    always #5 clk_i = ~clk_i;

    msft_dv_ip_i2c_xfer_sched #(
        .LEN_BITS      (LB),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i (cmd_addr_i),
        .cmd_rnw_i  (cmd_rnw_i),
        .cmd_len_i  (cmd_len_i),
        .tx_empty_i (tx_empty_i),
        .tx_rdata_i (tx_rdata_i),
        .tx_rd_o    (tx_rd_o),
        .rx_full_i  (rx_full_i),
        .rx_wr_o    (rx_wr_o),
        .rx_wdata_o (rx_wdata_o),
        .eng_req_o  (eng_req_o),
        .eng_op_o   (eng_op_o),
        .eng_wdata_o(eng_wdata_o),
        .eng_nack_o (eng_nack_o),
        .eng_done_i (eng_done_i),
        .eng_nack_i (eng_nack_i),
        .eng_rdata_i(eng_rdata_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .byte_cnt_o (byte_cnt_o),
        .done_o     (done_o),
        .err_nack_o (err_nack_o),
        .err_tmo_o  (err_tmo_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [10:0] op_q[$];
    logic [7:0]  rx_q[$];
    logic [1:0]  done_q[$];
    logic [7:0]  txq[$];
    logic [7:0]  rdata_q[$];
    bit          nackw_q[$];
    logic [10:0] cur_exp;

    int tx_ptr    = 0;
    int eng_lat   = 1;
    bit junk_nack = 0;
    bit spur_done = 0;
    int full_hold = 0;
    int full_left = 0;
    int stall_cnt = 0;
    int tx_pops   = 0;
    int done_cnt  = 0;
    int req_cnt   = 0;
    bit req_seen  = 0;
    int lat_left  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] obs_op();
        logic [7:0] d;
        logic       n;
        d = (eng_op_o == OP_WR) ? eng_wdata_o : 8'h00;
        n = (eng_op_o == OP_RD) ? eng_nack_o : 1'b0;
        return {eng_op_o, d, n};
    endfunction

    function automatic logic [35:0] outs();
        return {cmd_ready_o, tx_rd_o, rx_wr_o, rx_wdata_o, eng_req_o,
                eng_op_o, eng_wdata_o, eng_nack_o, busy_o, stall_o,
                byte_cnt_o, done_o, err_nack_o, err_tmo_o};
    endfunction

    task automatic eo(input logic [1:0] op, input logic [7:0] d,
                      input logic n);
        op_q.push_back({op, d, n});
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs.
    task automatic tick();
        @(negedge clk_i);
        if (stall_o) stall_cnt++;
        if (tx_rd_o) begin
            tx_pops++;
            tx_ptr++;
        end
        if (rx_wr_o) begin
            chk("rx_expected", 64'(rx_q.size() != 0), 64'd1);
            if (rx_q.size() != 0) chk("rx_data", 64'(rx_wdata_o), 64'(rx_q.pop_front()));
        end
        if (done_o) begin
            done_cnt++;
            chk("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0)
                chk("done_err", 64'({err_nack_o, err_tmo_o}), 64'(done_q.pop_front()));
        end
        if (full_left > 0) full_left--;
        if (rx_wr_o && full_hold > 0) begin
            full_left = full_hold;
            full_hold = 0;
        end
        rx_full_i  = (full_left > 0);
        tx_empty_i = (tx_ptr >= txq.size());
        tx_rdata_i = tx_empty_i ? 8'h00 : txq[tx_ptr];
        eng_done_i  = 1'b0;
        eng_nack_i  = 1'b0;
        eng_rdata_i = 8'h00;
        if (!eng_req_o) begin
            req_seen = 0;
            if (spur_done) eng_done_i = 1'b1;
        end else if (!req_seen) begin
            req_seen = 1;
            req_cnt++;
            lat_left = eng_lat;
            chk("eng_expected", 64'(op_q.size() != 0), 64'd1);
            if (op_q.size() != 0) cur_exp = op_q.pop_front();
            else cur_exp = '1;
        end else if (lat_left > 0) begin
            lat_left--;
        end else if (lat_left == 0) begin
            lat_left = -1;
            chk("eng_op", 64'(obs_op()), 64'(cur_exp));
            eng_done_i = 1'b1;
            if (eng_op_o == OP_WR)
                eng_nack_i = (nackw_q.size() != 0) ? nackw_q.pop_front() : 1'b0;
            else
                eng_nack_i = junk_nack;
            if (eng_op_o == OP_RD && rdata_q.size() != 0)
                eng_rdata_i = rdata_q.pop_front();
        end
    endtask

    task automatic send(input logic [6:0] a, input logic r,
                        input logic [7:0] l);
        chk("cmd_ready", 64'(cmd_ready_o), 64'd1);
        cmd_addr_i  = a;
        cmd_rnw_i   = r;
        cmd_len_i   = l;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic sb_empty(input string tag);
        chk(tag, 64'(op_q.size() + rx_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic tx_load(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n);
        txq.delete();
        tx_ptr = 0;
        if (n > 0) txq.push_back(b0);
        if (n > 1) txq.push_back(b1);
        if (n > 2) txq.push_back(b2);
    endtask

    initial begin
        int p0;
        int s0;
        int r0;
        int n;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_rnw_i   = 1'b0;
        cmd_len_i   = '0;
        tx_empty_i  = 1'b1;
        tx_rdata_i  = '0;
        rx_full_i   = 1'b0;
        eng_done_i  = 1'b0;
        eng_nack_i  = 1'b0;
        eng_rdata_i = '0;
        repeat (3) tick();
        chk("reset_outs", 64'(outs()), 64'(RST_OUTS));
        rst_i = 1'b0;
        tick();

        // write 0x50, AA BB CC
        tx_load(8'hAA, 8'hBB, 8'hCC, 3);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'hA0, 0);
        eo(OP_WR, 8'hAA, 0); eo(OP_WR, 8'hBB, 0); eo(OP_WR, 8'hCC, 0);
        eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b00);
        p0 = tx_pops;
        send(7'h50, 1'b0, 8'd3);
        chk("wr_busy", 64'(busy_o), 64'd1);
        wait_done(500);
        chk("wr_pops", 64'(tx_pops - p0), 64'd3);
        chk("wr_cnt", 64'(byte_cnt_o), 64'd3);
        sb_empty("wr_sb");

        // read 0x21, 5A 3C; engine NACK noise on non-write ops
        junk_nack = 1;
        rdata_q.push_back(8'h5A); rdata_q.push_back(8'h3C);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h43, 0);
        eo(OP_RD, 8'h00, 0); eo(OP_RD, 8'h00, 1); eo(OP_SP, 8'h00, 0);
        rx_q.push_back(8'h5A); rx_q.push_back(8'h3C);
        done_q.push_back(2'b00);
        send(7'h21, 1'b1, 8'd2);
        wait_done(500);
        chk("rd_cnt", 64'(byte_cnt_o), 64'd2);
        sb_empty("rd_sb");
        junk_nack = 0;

        // address NACK
        tx_load(8'h11, 8'h22, 8'h00, 2);
        nackw_q.push_back(1'b1);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'hE4, 0); eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b10);
        p0 = tx_pops;
        send(7'h72, 1'b0, 8'd2);
        wait_done(500);
        chk("anack_pops", 64'(tx_pops - p0), 64'd0);
        chk("anack_cnt", 64'(byte_cnt_o), 64'd0);
        sb_empty("anack_sb");

        // data NACK on second byte still counts it
        tx_load(8'h01, 8'h02, 8'h03, 3);
        nackw_q.push_back(1'b0); nackw_q.push_back(1'b0); nackw_q.push_back(1'b1);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h14, 0);
        eo(OP_WR, 8'h01, 0); eo(OP_WR, 8'h02, 0); eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b10);
        p0 = tx_pops;
        send(7'h0A, 1'b0, 8'd3);
        wait_done(500);
        chk("dnack_pops", 64'(tx_pops - p0), 64'd2);
        chk("dnack_cnt", 64'(byte_cnt_o), 64'd2);
        sb_empty("dnack_sb");

        // read with RX full for 20 cycles before 2nd byte
        full_hold = 20;
        rdata_q.push_back(8'h11); rdata_q.push_back(8'h22);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h67, 0);
        eo(OP_RD, 8'h00, 0); eo(OP_RD, 8'h00, 1); eo(OP_SP, 8'h00, 0);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        done_q.push_back(2'b00);
        s0 = stall_cnt;
        send(7'h33, 1'b1, 8'd2);
        wait_done(500);
        chk("stall_cycles", 64'(stall_cnt - s0), 64'd20);
        chk("stall_cnt", 64'(byte_cnt_o), 64'd2);
        sb_empty("stall_sb");

        // len=0 probe, spurious done pulses, command while busy
        spur_done = 1;
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h7E, 0); eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b00);
        r0 = req_cnt;
        send(7'h3F, 1'b0, 8'd0);
        repeat (2) tick();
        cmd_addr_i  = 7'h55;
        cmd_len_i   = 8'd1;
        cmd_valid_i = 1'b1;
        repeat (3) tick();
        cmd_valid_i = 1'b0;
        wait_done(500);
        repeat (10) tick();
        spur_done = 0;
        chk("probe_reqs", 64'(req_cnt - r0), 64'd3);
        chk("probe_idle", 64'(busy_o), 64'd0);
        sb_empty("probe_sb");

        // maximum length read
        eng_lat = 0;
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h03, 0);
        for (int i = 0; i < 255; i++) begin
            eo(OP_RD, 8'h00, (i == 254));
            rdata_q.push_back(8'(i * 7));
            rx_q.push_back(8'(i * 7));
        end
        eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b00);
        send(7'h01, 1'b1, 8'd255);
        wait_done(5000);
        chk("max_cnt", 64'(byte_cnt_o), 64'd255);
        sb_empty("max_sb");
        eng_lat = 1;

`ifdef I2C_SCHED_TIMEOUT_EN
        // TX stays empty: watchdog aborts after 16 stall cycles
        tx_load(8'h00, 8'h00, 8'h00, 0);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'h90, 0); eo(OP_SP, 8'h00, 0);
        done_q.push_back(2'b01);
        s0 = stall_cnt;
        p0 = tx_pops;
        send(7'h48, 1'b0, 8'd2);
        wait_done(500);
        chk("tmo_stall", 64'(stall_cnt - s0), 64'd16);
        chk("tmo_pops", 64'(tx_pops - p0), 64'd0);
        sb_empty("tmo_sb");
`endif

        // reset while a data WRITE is outstanding
        eng_lat = 10;
        tx_load(8'hAA, 8'hBB, 8'hCC, 3);
        eo(OP_ST, 8'h00, 0); eo(OP_WR, 8'hA0, 0); eo(OP_WR, 8'hAA, 0);
        r0 = req_cnt;
        send(7'h50, 1'b0, 8'd3);
        n = 0;
        while (req_cnt < r0 + 3 && n < 300) begin
            tick();
            n++;
        end
        chk("mid_data_reached", 64'(req_cnt - r0), 64'd3);
        chk("mid_data_op", 64'(obs_op()), 64'({OP_WR, 8'hAA, 1'b0}));
        rst_i = 1'b1;
        tick();
        chk("mid_rst_outs", 64'(outs()), 64'(RST_OUTS));
        rst_i = 1'b0;
        r0 = req_cnt;
        repeat (30) tick();
        chk("mid_rst_no_stop", 64'(req_cnt - r0), 64'd0);
        sb_empty("mid_rst_sb");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
